// File: rtl/sync_debounce_bank_pkg.sv
// Shared types and constants for the synchronizer/debounce bank.
//   edge_mode_e     : per-channel event select (off / rise / fall / both)
//   SYNC_STAGES_MIN : shallowest synchronizer chain that is metastability-safe
package sync_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  localparam int unsigned SYNC_STAGES_MIN = 2;

  // True when the mode reports rising transitions.
  function automatic logic wants_rise(edge_mode_e m);
    return (m == EDGE_RISE) || (m == EDGE_BOTH);
  endfunction

  // True when the mode reports falling transitions.
  function automatic logic wants_fall(edge_mode_e m);
    return (m == EDGE_FALL) || (m == EDGE_BOTH);
  endfunction

endpackage

// File: rtl/sync_debounce_bank_if.sv
// Signal bundle between the debounce bank and its user.
//   i_async / i_debounce_len / i_edge_mode : inputs into the bank
//   o_sync, o_*_pulse, o_event_any         : registered results
// master = the side driving the inputs, slave = the bank itself.
interface sync_debounce_bank_if #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DEBOUNCE_W = 8
);

  logic [N_CH-1:0]       i_async;
  logic [DEBOUNCE_W-1:0] i_debounce_len;
  logic [2*N_CH-1:0]     i_edge_mode;
  logic [N_CH-1:0]       o_sync;
  logic [N_CH-1:0]       o_rise_pulse;
  logic [N_CH-1:0]       o_fall_pulse;
  logic [N_CH-1:0]       o_event_pulse;
  logic                  o_event_any;

  modport master (
    output i_async, i_debounce_len, i_edge_mode,
    input  o_sync, o_rise_pulse, o_fall_pulse, o_event_pulse, o_event_any
  );

  modport slave (
    input  i_async, i_debounce_len, i_edge_mode,
    output o_sync, o_rise_pulse, o_fall_pulse, o_event_pulse, o_event_any
  );

endinterface

// File: rtl/sync_debounce_bank_ch.sv
// One channel: SYNC_STAGES-deep synchronizer followed by a stability counter.
//   clk, rst_n      : clock, async active-low reset
//   i_async         : raw asynchronous level
//   i_debounce_len  : required extra stable edges L (0 = accept immediately)
//   i_edge_mode     : which accepted transitions raise o_event_pulse
//   o_sync          : debounced level
//   o_rise/fall/event_pulse : one-cycle pulses for accepted transitions
//   o_event_c       : combinational next value of o_event_pulse (for bank OR)
module sync_debounce_ch
  import sync_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned DEBOUNCE_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_async,
  input  logic [DEBOUNCE_W-1:0] i_debounce_len,
  input  edge_mode_e            i_edge_mode,
  output logic                  o_sync,
  output logic                  o_rise_pulse,
  output logic                  o_fall_pulse,
  output logic                  o_event_pulse,
  output logic                  o_event_c
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DEBOUNCE_W-1:0]  cnt_q;
  logic [DEBOUNCE_W-1:0]  cnt_d;
  logic                   level_d;
  logic                   rise_d;
  logic                   fall_d;
  logic                   event_d;
  logic                   s;

  assign s         = sync_q[SYNC_STAGES-1];
  assign o_event_c = event_d;

  // Synchronizer chain, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '0;
      cnt_q         <= '0;
      o_sync        <= 1'b0;
      o_rise_pulse  <= 1'b0;
      o_fall_pulse  <= 1'b0;
      o_event_pulse <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], i_async};
      cnt_q         <= cnt_d;
      o_sync        <= level_d;
      o_rise_pulse  <= rise_d;
      o_fall_pulse  <= fall_d;
      o_event_pulse <= event_d;
    end
  end

  // Accept once the mismatch has already persisted for L edges; the
  // cnt_q >= L test also makes a shortened L take effect immediately
  // and keeps the counter from wrapping at all-ones.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = o_sync;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s == o_sync) begin
      cnt_d = '0;
    end else if (cnt_q < i_debounce_len) begin
      cnt_d = cnt_q + DEBOUNCE_W'(1);
    end else begin
      cnt_d   = '0;
      level_d = s;
      rise_d  = s;
      fall_d  = ~s;
    end
    event_d = (rise_d & wants_rise(i_edge_mode)) | (fall_d & wants_fall(i_edge_mode));
  end

endmodule

// File: rtl/sync_debounce_bank.sv
// Bank of N_CH independent synchronize-and-debounce channels.
//   clk, rst_n : clock, async active-low reset
//   bus        : inputs (i_async, i_debounce_len, i_edge_mode) and
//                registered outputs (o_sync, pulses, o_event_any)
module sync_debounce_bank
  import sync_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned DEBOUNCE_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  sync_debounce_bank_if.slave bus
);

  // Reject unusable parameterisations at elaboration.
  if (SYNC_STAGES < SYNC_STAGES_MIN || N_CH < 1 || N_CH > 32) begin : g_bad_param
    $error("sync_debounce_bank: illegal N_CH or SYNC_STAGES");
  end

  logic [N_CH-1:0] sync_v;
  logic [N_CH-1:0] rise_v;
  logic [N_CH-1:0] fall_v;
  logic [N_CH-1:0] event_v;
  logic [N_CH-1:0] event_c;
  logic            event_any_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    sync_debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_W (DEBOUNCE_W)
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_async       (bus.i_async[c]),
      .i_debounce_len(bus.i_debounce_len),
      .i_edge_mode   (edge_mode_e'(bus.i_edge_mode[2*c +: 2])),
      .o_sync        (sync_v[c]),
      .o_rise_pulse  (rise_v[c]),
      .o_fall_pulse  (fall_v[c]),
      .o_event_pulse (event_v[c]),
      .o_event_c     (event_c[c])
    );
  end

  // Registered from the same next-state terms so it aligns with o_event_pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) event_any_q <= 1'b0;
    else        event_any_q <= |event_c;
  end

  assign bus.o_sync        = sync_v;
  assign bus.o_rise_pulse  = rise_v;
  assign bus.o_fall_pulse  = fall_v;
  assign bus.o_event_pulse = event_v;
  assign bus.o_event_any   = event_any_q;

endmodule

// File: tb/tb_sync_debounce_bank.sv
module tb_sync_debounce_bank;

  localparam int unsigned N_CH = 4;
  localparam int unsigned SS   = 3;
  localparam int unsigned DW   = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sync_debounce_bank_if #(.N_CH(N_CH), .DEBOUNCE_W(DW)) bus ();

  sync_debounce_bank #(.N_CH(N_CH), .SYNC_STAGES(SS), .DEBOUNCE_W(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct packed {
    logic [N_CH-1:0] sync;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] ev;
    logic            any;
  } exp_t;

  exp_t            exp_q[$];
  logic [N_CH-1:0] delay_q[$];    // raw inputs still travelling through the synchronizer
  logic [N_CH-1:0] m_level;       // reference debounced level
  int unsigned     m_run[N_CH];   // consecutive edges the sample has disagreed with m_level
  int              vectors     = 0;
  int              miscompares = 0;

  task automatic model_reset();
    exp_q.delete();
    delay_q.delete();
    repeat (SS) delay_q.push_back('0);
    m_level = '0;
    for (int c = 0; c < N_CH; c++) m_run[c] = 0;
  endtask

  // Reference: a level is accepted once the synchronized sample has disagreed
  // with the current level for more than L consecutive edges.
  task automatic model_step();
    logic [N_CH-1:0] smp;
    logic [1:0]      mode;
    exp_t            e;
    int unsigned     len;
    smp = delay_q.pop_front();
    delay_q.push_back(bus.i_async);
    len = int'(bus.i_debounce_len);
    e   = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (smp[c] == m_level[c]) begin
        m_run[c] = 0;
      end else begin
        m_run[c] = m_run[c] + 1;
        if (m_run[c] > len) begin
          m_level[c] = smp[c];
          m_run[c]   = 0;
          mode       = bus.i_edge_mode[2*c +: 2];
          if (smp[c]) begin
            e.rise[c] = 1'b1;
            e.ev[c]   = (mode == 2'b01) || (mode == 2'b11);
          end else begin
            e.fall[c] = 1'b1;
            e.ev[c]   = (mode == 2'b10) || (mode == 2'b11);
          end
        end
      end
    end
    e.sync = m_level;
    e.any  = |e.ev;
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    if (rst_n) model_step();
  end

  // Monitor: after every active edge out of reset, compare against the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        if (bus.o_sync !== e.sync || bus.o_rise_pulse !== e.rise || bus.o_fall_pulse !== e.fall ||
            bus.o_event_pulse !== e.ev || bus.o_event_any !== e.any) begin
          miscompares++;
          $display("FAIL cycle_check t=%0t got sync=%b rise=%b fall=%b ev=%b any=%b exp sync=%b rise=%b fall=%b ev=%b any=%b",
                   $time, bus.o_sync, bus.o_rise_pulse, bus.o_fall_pulse, bus.o_event_pulse,
                   bus.o_event_any, e.sync, e.rise, e.fall, e.ev, e.any);
        end
      end
    end
  end

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_zero(string name);
    vectors++;
    if (bus.o_sync !== '0 || bus.o_rise_pulse !== '0 || bus.o_fall_pulse !== '0 ||
        bus.o_event_pulse !== '0 || bus.o_event_any !== 1'b0) begin
      miscompares++;
      $display("FAIL %s got sync=%b rise=%b fall=%b ev=%b any=%b exp all zero", name,
               bus.o_sync, bus.o_rise_pulse, bus.o_fall_pulse, bus.o_event_pulse, bus.o_event_any);
    end
  endtask

  task automatic do_reset(int hold);
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_clears");
    model_reset();
    repeat (hold) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Count edges until the rise pulse of a channel appears (bounded).
  task automatic expect_rise_after(int ch, int exp_edges, string name);
    int k;
    k = 0;
    while (k < 300) begin
      @(posedge clk);
      #1;
      k++;
      if (bus.o_rise_pulse[ch]) break;
    end
    vectors++;
    if (k != exp_edges) begin
      miscompares++;
      $display("FAIL %s edges=%0d expected=%0d", name, k, exp_edges);
    end
  endtask

  initial begin
    logic [N_CH-1:0] mask;
    bus.i_async        = '0;
    bus.i_debounce_len = '0;
    bus.i_edge_mode    = '1;
    model_reset();
    rst_n = 1'b0;
    #1;
    check_all_zero("reset_state");
    cycles(3);
    rst_n = 1'b1;

    // L=0: ch0 latency through the synchronizer only.
    cycles(4);
    bus.i_async[0] = 1'b1;
    expect_rise_after(0, SS + 1, "l0_latency");
    cycles(4);
    bus.i_async[0] = 1'b0;
    cycles(8);

    // L=4: a 3-cycle glitch is rejected, a 10-cycle pulse is accepted.
    bus.i_debounce_len = DW'(4);
    bus.i_async[1] = 1'b1;
    cycles(3);
    bus.i_async[1] = 1'b0;
    cycles(15);
    bus.i_async[1] = 1'b1;
    cycles(10);
    bus.i_async[1] = 1'b0;
    cycles(20);

    // ch2 fall-only events.
    bus.i_edge_mode[5:4] = 2'b10;
    bus.i_async[2] = 1'b1;
    cycles(12);
    bus.i_async[2] = 1'b0;
    cycles(12);

    // All channels together, both-edge events.
    bus.i_edge_mode    = '1;
    bus.i_debounce_len = DW'(2);
    bus.i_async        = '1;
    cycles(10);
    bus.i_async = '0;
    cycles(10);

    // Reset mid-count with other channels already high.
    bus.i_async[3:2] = 2'b11;
    cycles(10);
    bus.i_debounce_len = DW'(8);
    bus.i_async[0] = 1'b1;
    cycles(8);
    bus.i_async[3:2] = 2'b00;
    do_reset(3);
    expect_rise_after(0, SS + 8 + 1, "reset_release_rise");
    cycles(4);

    // Lowering L while ch3 has counted to 6.
    bus.i_debounce_len = DW'(10);
    bus.i_async[3] = 1'b1;
    cycles(9);
    bus.i_debounce_len = DW'(2);
    @(posedge clk);
    #1;
    vectors++;
    if (bus.o_sync[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL l_lowered got o_sync[3]=%b expected 1", bus.o_sync[3]);
    end
    cycles(6);

    // Maximal L: counter saturates at all-ones then accepts.
    bus.i_debounce_len = '1;
    bus.i_async[0] = 1'b0;
    cycles(270);

    // Randomized traffic with occasional L/mode changes and resets.
    for (int t = 0; t < 3000; t++) begin
      mask = '0;
      for (int c = 0; c < N_CH; c++) if ($urandom_range(7) == 0) mask[c] = 1'b1;
      bus.i_async = bus.i_async ^ mask;
      if ($urandom_range(63) == 0) bus.i_debounce_len = DW'($urandom_range(6));
      if ($urandom_range(127) == 0) bus.i_edge_mode = (2*N_CH)'($urandom);
      if ($urandom_range(1499) == 0) do_reset(2);
      else cycles(1);
    end
    cycles(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
